// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push arbiter: FSM state encoding,
// beat-counter sizing and the wrap-around first-set-bit search.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DRAIN
  } arb_state_e;

  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned MAX_PTR_W = 4;

  function automatic int unsigned beat_cnt_w(input int unsigned maxBurst);
    return $clog2(maxBurst + 1);
  endfunction

  // One-hot of the first set bit of req at or after ptr, wrapping within n bits.
  function automatic logic [MAX_REQ-1:0] first_set_from(
    input logic [MAX_REQ-1:0]   req,
    input logic [MAX_PTR_W-1:0] ptr,
    input int unsigned          n
  );
    logic [MAX_REQ-1:0] pick;
    logic               found;
    int unsigned        idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = i + 32'(ptr);
      if (idx >= n) idx = idx - n;
      if (i < n && !found && req[idx[MAX_PTR_W-1:0]]) begin
        pick[idx[MAX_PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational one-hot pick of the first pending request at or after a pointer.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_o
);

  assign pick_o = NUM_REQ'(first_set_from(MAX_REQ'(req_i), MAX_PTR_W'(ptr_i), NUM_REQ));

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares one FIFO push port among NUM_REQ push masters; grants are held per transfer or burst.
// Define FIFO_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      stream_mode,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [NUM_REQ-1:0]        ack_pulse_o,
  output logic [NUM_REQ-1:0]        full_o,
  output logic                      fifo_req_o,
  output logic [DATA_W-1:0]         fifo_data_o,
  input  logic                      fifo_ack_i,
  input  logic                      fifo_ack_pulse_i,
  input  logic                      fifo_full_i,
  output logic [NUM_REQ-1:0]        grant_o
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = int'(beat_cnt_w(MAX_BURST));
  localparam logic [BEAT_W-1:0] BURST_CAP = BEAT_W'(MAX_BURST);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  arb_state_e          state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [PTR_W-1:0]    grantIdx_q;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                mode_q;

  logic [NUM_REQ-1:0]  pick;
  logic [PTR_W-1:0]    pickIdx;
  logic [PTR_W-1:0]    pickPtr;
  logic                reqG, capHit, fifoReq, xfer;
  logic                relAdv, relHold;
  logic [DATA_W-1:0]   dataArr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_split
    assign dataArr[k] = data_i[k*DATA_W +: DATA_W];
  end

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i  (req_i),
    .ptr_i  (pickPtr),
    .pick_o (pick)
  );

  always_comb begin
    pickIdx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick[k]) pickIdx = PTR_W'(k);
    end
  end

  assign reqG        = req_i[grantIdx_q];
  assign capHit      = mode_q && (beat_q >= BURST_CAP);
  assign fifoReq     = (state_q == GRANT) && reqG && !capHit;
  assign xfer        = fifoReq && fifo_ack_i;
  assign fifo_req_o  = fifoReq;
  assign ack_o       = xfer ? grant_q : '0;
  assign ack_pulse_o = (fifoReq && fifo_ack_pulse_i) ? grant_q : '0;
  assign fifo_data_o = (|grant_q) ? dataArr[grantIdx_q] : '0;
  assign full_o      = {NUM_REQ{fifo_full_i}};
  assign grant_o     = grant_q;

  // relAdv releases the grant and moves priority past g; relHold is the handshake abort.
  always_comb begin
    relAdv  = 1'b0;
    relHold = 1'b0;
    beat_d  = beat_q;
    case (state_q)
      GRANT: begin
        if (mode_q) begin
          if (xfer) beat_d = beat_q + BEAT_ONE;
          if (!reqG || capHit || (xfer && beat_d == BURST_CAP)) relAdv = 1'b1;
        end else if (!xfer && !reqG) begin
          relHold = 1'b1;
        end
      end
      DRAIN:   if (!reqG) relAdv = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grantIdx_q <= '0;
      beat_q     <= '0;
      mode_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            grant_q    <= pick;
            grantIdx_q <= pickIdx;
            mode_q     <= stream_mode;
            beat_q     <= '0;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          beat_q <= beat_d;
          if (relAdv || relHold) begin
            grant_q <= '0;
            state_q <= IDLE;
          end else if (!mode_q && xfer) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (relAdv) begin
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_FIXED_PRIO_EN
  assign pickPtr = '0;
`else
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W-1:0] IDX_ONE  = PTR_W'(1);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  assign ptr_d   = (grantIdx_q == LAST_IDX) ? '0 : grantIdx_q + IDX_ONE;
  assign pickPtr = ptr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else if (relAdv) ptr_q <= ptr_d;
  end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed self-checking bench for fifo_push_arbiter (NUM_REQ=4, DATA_W=64, MAX_BURST=8).
module tb_fifo_push_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 64;
  localparam int MAX_BURST = 8;

  logic                      clk = 1'b0;
  logic                      rstn = 1'b0;
  logic                      stream_mode = 1'b0;
  logic [NUM_REQ-1:0]        req_i = '0;
  logic [NUM_REQ*DATA_W-1:0] data_i = '0;
  logic [NUM_REQ-1:0]        ack_o, ack_pulse_o, full_o, grant_o;
  logic                      fifo_req_o;
  logic [DATA_W-1:0]         fifo_data_o;
  logic                      fifo_ack_i = 1'b0;
  logic                      fifo_ack_pulse_i = 1'b0;
  logic                      fifo_full_i = 1'b0;

  int compared = 0;
  int mismatched = 0;
  logic [DATA_W-1:0] word [NUM_REQ];

  fifo_push_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .stream_mode      (stream_mode),
    .req_i            (req_i),
    .data_i           (data_i),
    .ack_o            (ack_o),
    .ack_pulse_o      (ack_pulse_o),
    .full_o           (full_o),
    .fifo_req_o       (fifo_req_o),
    .fifo_data_o      (fifo_data_o),
    .fifo_ack_i       (fifo_ack_i),
    .fifo_ack_pulse_i (fifo_ack_pulse_i),
    .fifo_full_i      (fifo_full_i),
    .grant_o          (grant_o)
  );

  always #5 clk = ~clk;

  // Inputs change just after the falling edge, outputs are sampled 2ns later.
  task automatic doReset();
    rstn = 1'b0;
    req_i = '0; stream_mode = 1'b0; fifo_ack_i = 1'b0; fifo_ack_pulse_i = 1'b0; fifo_full_i = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req_i = 4'b1111; fifo_ack_i = 1'b1; fifo_ack_pulse_i = 1'b1; fifo_full_i = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    compared++; if (grant_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_grant: got %b want 0000", grant_o); end
    compared++; if (fifo_req_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_fifo_req: got %b want 0", fifo_req_o); end
    compared++; if (ack_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_ack: got %b want 0000", ack_o); end
    compared++; if (ack_pulse_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_ack_pulse: got %b want 0000", ack_pulse_o); end
    compared++; if (fifo_data_o !== 64'h0) begin mismatched++; $display("[TB] FAIL reset_data: got %h want 0", fifo_data_o); end
    compared++; if (full_o !== 4'b1111) begin mismatched++; $display("[TB] FAIL reset_full_hi: got %b want 1111", full_o); end
    fifo_full_i = 1'b0;
    #1;
    compared++; if (full_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_full_lo: got %b want 0000", full_o); end
  endtask

  task automatic test_handshake_rr();
    int expOrder [5] = '{0, 1, 2, 3, 0};
    int dropCnt [NUM_REQ] = '{0, 0, 0, 0};
    int waitCnt = 0;
    int xferIdx = 0;
    int e;
    logic [NUM_REQ-1:0] expVec;
    doReset();
    for (int cyc = 0; cyc < 80 && xferIdx < 5; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < NUM_REQ; k++) begin
        req_i[k] = (dropCnt[k] == 0);
        if (dropCnt[k] > 0) dropCnt[k]--;
      end
      #1;
      fifo_ack_i = fifo_req_o && (waitCnt >= 2);
      fifo_ack_pulse_i = fifo_ack_i;
      #1;
      if (fifo_req_o && fifo_ack_i) begin
        e = expOrder[xferIdx];
        expVec = 4'b0001 << e;
        compared++; if (ack_o !== expVec) begin mismatched++; $display("[TB] FAIL hs_ack[%0d]: got %b want %b", xferIdx, ack_o, expVec); end
        compared++; if (grant_o !== expVec) begin mismatched++; $display("[TB] FAIL hs_grant[%0d]: got %b want %b", xferIdx, grant_o, expVec); end
        compared++; if (fifo_data_o !== word[e]) begin mismatched++; $display("[TB] FAIL hs_data[%0d]: got %h want %h", xferIdx, fifo_data_o, word[e]); end
        for (int k = 0; k < NUM_REQ; k++) if (ack_o[k]) dropCnt[k] = 1;
        xferIdx++;
        waitCnt = 0;
      end else if (fifo_req_o) begin
        waitCnt++;
      end else begin
        waitCnt = 0;
      end
    end
    compared++; if (xferIdx !== 5) begin mismatched++; $display("[TB] FAIL hs_transfers: got %0d want 5", xferIdx); end
    req_i = '0; fifo_ack_i = 1'b0; fifo_ack_pulse_i = 1'b0;
  endtask

  task automatic test_stream_cap();
    int ackCnt = 0, nRuns = 0, gapCnt = 0;
    int runLen [4] = '{0, 0, 0, 0};
    int gapLen [4] = '{0, 0, 0, 0};
    logic inRun = 1'b0, otherBad = 1'b0, push;
    doReset();
    stream_mode = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      req_i = (ackCnt < 20) ? 4'b0010 : 4'b0000;
      fifo_ack_i = 1'b1; fifo_ack_pulse_i = 1'b1;
      #2;
      push = fifo_req_o && fifo_ack_i;
      if (ack_o !== (push ? 4'b0010 : 4'b0000)) otherBad = 1'b1;
      if (push) begin
        ackCnt++;
        if (!inRun) begin
          if (nRuns > 0 && nRuns < 4) gapLen[nRuns-1] = gapCnt;
          nRuns++;
          inRun = 1'b1;
        end
        if (nRuns <= 4) runLen[nRuns-1]++;
      end else begin
        if (inRun) begin inRun = 1'b0; gapCnt = 0; end
        gapCnt++;
      end
    end
    compared++; if (ackCnt !== 20) begin mismatched++; $display("[TB] FAIL st_pushes: got %0d want 20", ackCnt); end
    compared++; if (nRuns !== 3) begin mismatched++; $display("[TB] FAIL st_bursts: got %0d want 3", nRuns); end
    compared++; if (runLen[0] !== 8) begin mismatched++; $display("[TB] FAIL st_len0: got %0d want 8", runLen[0]); end
    compared++; if (runLen[1] !== 8) begin mismatched++; $display("[TB] FAIL st_len1: got %0d want 8", runLen[1]); end
    compared++; if (runLen[2] !== 4) begin mismatched++; $display("[TB] FAIL st_len2: got %0d want 4", runLen[2]); end
    compared++; if (gapLen[0] !== 1) begin mismatched++; $display("[TB] FAIL st_gap0: got %0d want 1", gapLen[0]); end
    compared++; if (gapLen[1] !== 1) begin mismatched++; $display("[TB] FAIL st_gap1: got %0d want 1", gapLen[1]); end
    compared++; if (otherBad !== 1'b0) begin mismatched++; $display("[TB] FAIL st_ack_shape: got %b want 0", otherBad); end
    compared++; if (grant_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL st_release: got %b want 0000", grant_o); end
  endtask

  task automatic test_stream_alternate();
    int nRuns = 0, closed = 0, owner = 0, curOwner = -1;
    int runLen [4] = '{0, 0, 0, 0};
    int runOwner [4] = '{-1, -1, -1, -1};
    int expOwner [4] = '{0, 2, 0, 2};
    logic inRun = 1'b0, shapeBad = 1'b0, dataBad = 1'b0, push;
    doReset();
    stream_mode = 1'b1;
    for (int cyc = 0; cyc < 60 && closed < 4; cyc++) begin
      @(negedge clk);
      req_i = 4'b0101; fifo_ack_i = 1'b1; fifo_ack_pulse_i = 1'b1;
      #2;
      push = fifo_req_o && fifo_ack_i;
      if (push) begin
        owner = (ack_o === 4'b0001) ? 0 : (ack_o === 4'b0100) ? 2 : 99;
        if (owner == 99) shapeBad = 1'b1;
        else if (fifo_data_o !== word[owner]) dataBad = 1'b1;
        if (inRun && owner != curOwner) begin closed++; inRun = 1'b0; end
        if (!inRun) begin
          if (nRuns < 4) runOwner[nRuns] = owner;
          nRuns++;
          inRun = 1'b1;
          curOwner = owner;
        end
        if (nRuns <= 4) runLen[nRuns-1]++;
      end else begin
        if (ack_o !== 4'b0000) shapeBad = 1'b1;
        if (inRun) begin inRun = 1'b0; closed++; end
      end
    end
    compared++; if (closed !== 4) begin mismatched++; $display("[TB] FAIL alt_bursts: got %0d want 4", closed); end
    for (int i = 0; i < 4; i++) begin
      compared++; if (runOwner[i] !== expOwner[i]) begin mismatched++; $display("[TB] FAIL alt_owner%0d: got %0d want %0d", i, runOwner[i], expOwner[i]); end
      compared++; if (runLen[i] !== MAX_BURST) begin mismatched++; $display("[TB] FAIL alt_len%0d: got %0d want %0d", i, runLen[i], MAX_BURST); end
    end
    compared++; if (shapeBad !== 1'b0) begin mismatched++; $display("[TB] FAIL alt_ack_shape: got %b want 0", shapeBad); end
    compared++; if (dataBad !== 1'b0) begin mismatched++; $display("[TB] FAIL alt_data: got %b want 0", dataBad); end
    req_i = '0;
  endtask

  task automatic test_full_backpressure();
    logic fullBad = 1'b0, ackBad = 1'b0, grantBad = 1'b0;
    doReset();
    req_i = 4'b0100; fifo_full_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      if (full_o !== 4'b1111) fullBad = 1'b1;
      if (ack_o !== 4'b0000 || ack_pulse_o !== 4'b0000) ackBad = 1'b1;
      if (grant_o !== 4'b0100) grantBad = 1'b1;
    end
    compared++; if (fullBad !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_full: got %b want 0", fullBad); end
    compared++; if (ackBad !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_no_ack: got %b want 0", ackBad); end
    compared++; if (grantBad !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_grant_held: got %b want 0", grantBad); end
    @(negedge clk);
    fifo_full_i = 1'b0; fifo_ack_i = 1'b1; fifo_ack_pulse_i = 1'b1;
    #2;
    compared++; if (ack_o !== 4'b0100) begin mismatched++; $display("[TB] FAIL bp_ack: got %b want 0100", ack_o); end
    compared++; if (ack_pulse_o !== 4'b0100) begin mismatched++; $display("[TB] FAIL bp_ack_pulse: got %b want 0100", ack_pulse_o); end
    compared++; if (fifo_data_o !== word[2]) begin mismatched++; $display("[TB] FAIL bp_data: got %h want %h", fifo_data_o, word[2]); end
    @(negedge clk);
    #2;
    compared++; if (fifo_req_o !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_drain_req: got %b want 0", fifo_req_o); end
    compared++; if (ack_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL bp_drain_ack: got %b want 0000", ack_o); end
    req_i = '0; fifo_ack_i = 1'b0; fifo_ack_pulse_i = 1'b0;
    @(negedge clk);
    #2;
    compared++; if (grant_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL bp_release: got %b want 0000", grant_o); end
  endtask

  task automatic test_abort();
    doReset();
    req_i = 4'b0100; fifo_ack_i = 1'b1; fifo_ack_pulse_i = 1'b1;
    @(negedge clk);
    #2;
    compared++; if (ack_o !== 4'b0100) begin mismatched++; $display("[TB] FAIL ab_first_ack: got %b want 0100", ack_o); end
    @(negedge clk);
    req_i = '0; fifo_ack_i = 1'b0; fifo_ack_pulse_i = 1'b0;
    @(negedge clk);
    req_i = 4'b1000;
    @(negedge clk);
    #2;
    compared++; if (grant_o !== 4'b1000) begin mismatched++; $display("[TB] FAIL ab_grant3: got %b want 1000", grant_o); end
    compared++; if (ack_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL ab_no_ack: got %b want 0000", ack_o); end
    @(negedge clk);
    req_i = '0;
    #2;
    compared++; if (fifo_req_o !== 1'b0) begin mismatched++; $display("[TB] FAIL ab_req_drop: got %b want 0", fifo_req_o); end
    @(negedge clk);
    req_i = 4'b1001;
    #2;
    compared++; if (grant_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL ab_idle: got %b want 0000", grant_o); end
    @(negedge clk);
    #2;
    compared++; if (grant_o !== 4'b1000) begin mismatched++; $display("[TB] FAIL ab_ptr_kept: got %b want 1000", grant_o); end
    compared++; if (fifo_data_o !== word[3]) begin mismatched++; $display("[TB] FAIL ab_data: got %h want %h", fifo_data_o, word[3]); end
    req_i = '0;
  endtask

  task automatic test_async_reset();
    doReset();
    stream_mode = 1'b1; req_i = 4'b0010; fifo_ack_i = 1'b1; fifo_ack_pulse_i = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    compared++; if (fifo_req_o !== 1'b1) begin mismatched++; $display("[TB] FAIL ar_mid_burst: got %b want 1", fifo_req_o); end
    rstn = 1'b0;
    #1;
    compared++; if (grant_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL ar_grant: got %b want 0000", grant_o); end
    compared++; if (fifo_req_o !== 1'b0) begin mismatched++; $display("[TB] FAIL ar_fifo_req: got %b want 0", fifo_req_o); end
    compared++; if (ack_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL ar_ack: got %b want 0000", ack_o); end
    compared++; if (ack_pulse_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL ar_ack_pulse: got %b want 0000", ack_pulse_o); end
    compared++; if (fifo_data_o !== 64'h0) begin mismatched++; $display("[TB] FAIL ar_data: got %h want 0", fifo_data_o); end
    req_i = 4'b1100;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #2;
    compared++; if (grant_o !== 4'b0100) begin mismatched++; $display("[TB] FAIL ar_first_grant: got %b want 0100", grant_o); end
    req_i = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int k = 0; k < NUM_REQ; k++) begin
      word[k] = {16'hA5A5, 16'(k), 32'h1357_0000 + 32'(k)};
      data_i[k*DATA_W +: DATA_W] = word[k];
    end
    test_reset();
    test_handshake_rr();
    test_stream_cap();
    test_stream_alternate();
    test_full_backpressure();
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
